// File: rtl/k_fifo_rd_ctrl_if.sv
// k_fifo_rd_ctrl_if: registered read-data stream between the FIFO read controller and its consumer
interface k_fifo_rd_ctrl_if #(parameter int data_size = 8);
  logic [data_size-1:0] rdata;
  logic                 rvalid;
  logic                 rready;
  modport master(output rdata, rvalid, input rready);
  modport slave(input rdata, rvalid, output rready);
endinterface

// File: rtl/k_fifo_rd_ctrl.sv
// k_fifo_rd_ctrl: dual-clock FIFO read side; syncs the write pointer, tracks empty/level, registers output data
module k_fifo_rd_ctrl #(
  parameter int data_size = 8,
  parameter int addr_size = 4
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  input  logic [addr_size:0]   wptr_gray,
  output logic [addr_size:0]   rptr_gray,
  output logic [addr_size-1:0] raddr,
  input  logic [data_size-1:0] mem_rdata,
  output logic                 rempty,
  output logic [addr_size:0]   rlevel,
  k_fifo_rd_ctrl_if.master     rd
);
  logic [addr_size:0] rptr_bin, rptr_nxt, wq1, wq2, wbin_sync;
  logic fetch;
  for (genvar i = 0; i <= addr_size; i++) begin : g_g2b
    assign wbin_sync[i] = ^wq2[addr_size:i];
  end
  assign rptr_nxt = rptr_bin + (addr_size+1)'(1);
  assign raddr    = rptr_bin[addr_size-1:0];
  assign rempty   = rptr_gray == wq2;
  assign rlevel   = wbin_sync - rptr_bin;
  assign fetch    = !rempty && (!rd.rvalid || rd.rready);
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rptr_bin  <= '0;
      rptr_gray <= '0;
      wq1       <= '0;
      wq2       <= '0;
      rd.rdata  <= '0;
      rd.rvalid <= 1'b0;
    end else begin
      wq1 <= wptr_gray;
      wq2 <= wq1;
      if (fetch) begin
        rd.rdata  <= mem_rdata;
        rd.rvalid <= 1'b1;
        rptr_bin  <= rptr_nxt;
        rptr_gray <= rptr_nxt ^ (rptr_nxt >> 1);
      end else if (rd.rvalid && rd.rready) begin
        rd.rvalid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_k_fifo_rd_ctrl.sv
// tb_k_fifo_rd_ctrl: randomized and directed checks of the FIFO read controller against a pointer/queue model
module tb_k_fifo_rd_ctrl;
  logic       rclk = 1'b0, rrst_n = 1'b0;
  logic [4:0] wptr_gray = 5'b00011, rptr_gray, rlevel;
  logic [3:0] raddr;
  logic [7:0] mem_rdata;
  logic       rempty;
  logic [7:0] mem [16];
  k_fifo_rd_ctrl_if #(.data_size(8)) rd();
  k_fifo_rd_ctrl #(.data_size(8), .addr_size(4)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .wptr_gray(wptr_gray), .rptr_gray(rptr_gray),
    .raddr(raddr), .mem_rdata(mem_rdata), .rempty(rempty), .rlevel(rlevel), .rd(rd)
  );
  always #5 rclk = ~rclk;
  assign mem_rdata = mem[raddr];
  int errors = 0, checks = 0;
  int wb = 0, m_rp = 0, wh1 = 0, wh2 = 0;
  bit m_v = 1'b0, armed = 1'b0;
  logic [7:0] m_d = 8'h00;
  logic [7:0] exp_q [$];
  function automatic logic [4:0] gray(int b);
    logic [4:0] x = b[4:0];
    return x ^ (x >> 1);
  endfunction
  function automatic int g2b(logic [4:0] g);
    logic [4:0] x;
    x[4] = g[4];
    for (int i = 3; i >= 0; i--) x[i] = x[i+1] ^ g[i];
    return int'(x);
  endfunction
  function automatic int lvl();
    return (wh2 - m_rp + 32) % 32;
  endfunction
  function automatic bit room();
    return (wb - m_rp + 32) % 32 < 16;
  endfunction
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge rclk);
    #1;
  endtask
  task automatic push(input logic [7:0] d);
    int n = 0;
    while (!room()) begin
      if (n++ > 200) begin
        chk("push_timeout", 1, 0);
        return;
      end
      tick();
    end
    mem[wb%16] = d;
    exp_q.push_back(d);
    wb = (wb + 1) % 32;
    wptr_gray = gray(wb);
  endtask
  task automatic rst_pulse();
    rrst_n = 1'b0;
    wb = 0;
    wptr_gray = 5'b0;
    exp_q.delete();
    tick();
    rrst_n = 1'b1;
  endtask
  // Reference: a word becomes visible two edges after its pointer is driven; the output slot refills whenever free or consumed
  always @(posedge rclk) begin
    if (!rrst_n) begin
      m_rp <= 0; m_v <= 1'b0; m_d <= 8'h00; wh1 <= 0; wh2 <= 0;
    end else begin
      if (lvl() != 0 && (!m_v || rd.rready)) begin
        m_d <= mem[m_rp%16]; m_v <= 1'b1; m_rp <= (m_rp + 1) % 32;
      end else if (m_v && rd.rready) m_v <= 1'b0;
      wh1 <= g2b(wptr_gray);
      wh2 <= wh1;
    end
  end
  always @(negedge rclk) begin
    if (armed) begin
      chk("rvalid", int'(rd.rvalid), int'(m_v));
      chk("rdata", int'(rd.rdata), int'(m_d));
      chk("rempty", int'(rempty), int'(lvl() == 0));
      chk("rlevel", int'(rlevel), lvl());
      chk("rptr_gray", int'(rptr_gray), int'(gray(m_rp)));
      chk("raddr", int'(raddr), m_rp % 16);
      if (rrst_n && rd.rvalid && rd.rready) begin
        if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
        else chk("sb_data", int'(rd.rdata), int'(exp_q.pop_front()));
      end
    end
  end
  initial begin
    int wa [4] = '{14, 15, 0, 1};
    logic [4:0] prev;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    rd.rready = 1'b0;
    tick();
    armed = 1'b1;
    tick();
    chk("rst_rvalid", int'(rd.rvalid), 0);
    chk("rst_rdata", int'(rd.rdata), 0);
    chk("rst_rempty", int'(rempty), 1);
    chk("rst_rptr_gray", int'(rptr_gray), 0);
    chk("rst_rlevel", int'(rlevel), 0);
    rrst_n = 1'b1;
    wptr_gray = 5'b0;
    tick(); chk("post_rst_empty1", int'(rempty), 1);
    tick(); chk("post_rst_empty2", int'(rempty), 1);
    push(8'hA5);
    tick(); chk("single_k_valid", int'(rd.rvalid), 0);
    tick(); chk("single_k1_valid", int'(rd.rvalid), 0); chk("single_k1_empty", int'(rempty), 0);
    tick();
    chk("single_valid", int'(rd.rvalid), 1);
    chk("single_data", int'(rd.rdata), 8'hA5);
    chk("single_gray", int'(rptr_gray), 5'b00001);
    chk("single_empty", int'(rempty), 1);
    rd.rready = 1'b1;
    tick(); chk("single_consumed", int'(rd.rvalid), 0);
    rd.rready = 1'b0;
    rst_pulse();
    rd.rready = 1'b1;
    for (int i = 0; i < 16; i++) push(8'(i));
    tick(); tick();
    chk("stream_level", int'(rlevel), 16);
    chk("stream_nonempty", int'(rempty), 0);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("stream_valid", int'(rd.rvalid), 1);
      chk("stream_data", int'(rd.rdata), i);
    end
    chk("stream_end_empty", int'(rempty), 1);
    chk("stream_end_raddr", int'(raddr), 0);
    chk("stream_end_gray", int'(rptr_gray), 5'b11000);
    tick(); chk("stream_drained", int'(rd.rvalid), 0);
    rst_pulse();
    rd.rready = 1'b0;
    push(8'hB0); push(8'hB1); push(8'hB2);
    repeat (5) tick();
    chk("bp_valid", int'(rd.rvalid), 1);
    chk("bp_data", int'(rd.rdata), 8'hB0);
    chk("bp_level", int'(rlevel), 2);
    chk("bp_gray", int'(rptr_gray), 5'b00001);
    rd.rready = 1'b1;
    tick(); chk("bp_word1", int'(rd.rdata), 8'hB1);
    tick(); chk("bp_word2", int'(rd.rdata), 8'hB2);
    tick(); chk("bp_done", int'(rd.rvalid), 0);
    for (int i = 0; i < 27; i++) push(8'($urandom));
    repeat (40) tick();
    chk("wrap_start_gray", int'(rptr_gray), int'(gray(30)));
    for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
    tick(); tick();
    prev = rptr_gray;
    for (int k = 0; k < 4; k++) begin
      chk("wrap_raddr", int'(raddr), wa[k]);
      tick();
      chk("wrap_gray_step", $countones(prev ^ rptr_gray), 1);
      prev = rptr_gray;
    end
    chk("wrap_end_raddr", int'(raddr), 2);
    rst_pulse();
    rd.rready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'hD0 + 8'(i));
    repeat (3) tick();
    chk("mid_valid", int'(rd.rvalid), 1);
    chk("mid_level", int'(rlevel), 5);
    rrst_n = 1'b0; wb = 0; wptr_gray = 5'b0; exp_q.delete();
    tick();
    chk("mid_rst_valid", int'(rd.rvalid), 0);
    chk("mid_rst_empty", int'(rempty), 1);
    chk("mid_rst_gray", int'(rptr_gray), 0);
    chk("mid_rst_level", int'(rlevel), 0);
    rrst_n = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(399) == 0) rst_pulse();
      else begin
        rd.rready = $urandom_range(3) != 0;
        repeat ($urandom_range(2)) if (room()) push(8'($urandom));
        tick();
      end
    end
    rd.rready = 1'b1;
    repeat (40) tick();
    chk("final_drained", int'(rempty), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
